dmem_responder: RTL

Data-memory responder for the MIPS core. It is the target end of the load/store path that the datapath drives through its ALU-result address, register write data and read-data return. It accepts one word request at a time over a valid/ready handshake and inserts a programmable number of wait states. It returns read data, or a store acknowledge, over a separate valid/ready response channel, so the core can be stalled against slow memory.

---
 rtl/dmem_responder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Data-memory target for the MIPS core load/store path. It accepts one word
//   request at a time over a valid/ready handshake. It then waits a fixed
//   number of wait states and performs the array access. Finally it returns
//   load data, or a store acknowledge, over a separate valid/ready response
//   channel. Only one transaction is ever outstanding, so a load that follows
//   a store to the same word always observes the stored value.
//
// Parameters:
//   WIDTH      data and address width in bits (default 32)
//   DEPTH_BITS log2 of storage depth in words (default 6 -> 64 words)
//   LATENCY    wait-state count, 0..15 (default 2)
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-high reset
//   req_valid  request present
//   req_ready  responder can accept a request (high only in IDLE)
//   req_write  1 = store, 0 = load (sampled on accept)
//   req_addr   byte address; word index = req_addr[DEPTH_BITS+1:2]
//   req_wdata  store data (sampled on accept)
//   rsp_valid  response present
//   rsp_ready  requester consumes the response
//   rsp_rdata  load data; 0 for stores and faults
//   rsp_err    access fault
//
// Build option:
//   DMEM_MISALIGN_TRAP_EN  when defined, a request whose req_addr[1:0] is not
//                          zero performs no array access. It still takes the
//                          full latency, and it responds with rsp_err=1 and
//                          rsp_rdata=0. When undefined, the low address bits
//                          are ignored and rsp_err is always 0.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 6,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int         DEPTH    = 1 << DEPTH_BITS;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [3:0]              cnt_reg;

  // Request fields captured on accept; the live request bus is ignored
  // after that point.
  logic                    write_reg;
  logic [DEPTH_BITS-1:0]   idx_reg;
  logic [WIDTH-1:0]        wdata_reg;
  logic                    fault_reg;

  // Registered outputs
  logic                    req_ready_reg;
  logic                    rsp_valid_reg;
  logic [WIDTH-1:0]        rsp_rdata_reg;
  logic                    rsp_err_reg;

  // Word storage; contents are deliberately not reset.
  logic [WIDTH-1:0]        mem [DEPTH];

  logic                    accept;
  logic                    access;
  logic                    req_fault;
  logic                    unused_addr_bits;

  // The address upper bits only alias the storage, and the byte offset is
  // used only by the fault check.
  assign unused_addr_bits = ^{req_addr[WIDTH-1:DEPTH_BITS+2], req_addr[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_fault = (req_addr[1:0] != 2'b00);
`else
  assign req_fault = 1'b0;
`endif

  assign accept = (state_reg == IDLE) && req_valid && req_ready_reg;

  // The access edge is the last WAIT cycle, after the counter has drained.
  assign access = (state_reg == WAIT) && (cnt_reg == 4'd0);

  // ---------------------------------------------------------------------------
  // Storage write port. It has no reset, so that the array can map onto RAM.
  // A reset before the access edge returns the FSM to IDLE, and the pending
  // store is then simply never performed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (access && write_reg && !fault_reg) begin
      mem[idx_reg] <= wdata_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake and response outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      write_reg     <= 1'b0;
      idx_reg       <= '0;
      wdata_reg     <= '0;
      fault_reg     <= 1'b0;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            write_reg     <= req_write;
            idx_reg       <= req_addr[DEPTH_BITS+1:2];
            wdata_reg     <= req_wdata;
            fault_reg     <= req_fault;
            cnt_reg       <= LAT_LOAD;
            req_ready_reg <= 1'b0;
            state_reg     <= WAIT;
          end else begin
            // This also raises ready on the first edge after reset release.
            req_ready_reg <= 1'b1;
          end
        end

        WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            // Stores and faulted requests both return zero data. A load
            // reads the word on this same edge, so it sees any earlier store.
            if (write_reg || fault_reg) begin
              rsp_rdata_reg <= '0;
            end else begin
              rsp_rdata_reg <= mem[idx_reg];
            end
            rsp_err_reg   <= fault_reg;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end

        RESP: begin
          // Data and error hold until consumed. No new request is taken here.
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          rsp_valid_reg <= 1'b0;
          req_ready_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule
